// File: rtl/wb_arbiter.sv
// Writeback-port arbiter: merges ALU results and buffered mul/div results onto the register-file write port.
// Latency: 1 cycle from winning edge to wr_en/a3/din (ALU and bypass); FIFO entries wait behind the ALU.
// Backpressure: md_ready = !full from registered occupancy; the ALU is never stalled, alu_hold requests a gap.
module wb_arbiter #(
  parameter int D_WIDTH       = 32,
  parameter int ADDRESS_WIDTH = 5,
  parameter int DEPTH         = 4,
  parameter int STARVE_LIMIT  = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     alu_valid,
  input  logic [ADDRESS_WIDTH-1:0] alu_rd,
  input  logic [D_WIDTH-1:0]       alu_data,
  input  logic                     md_valid,
  output logic                     md_ready,
  input  logic [ADDRESS_WIDTH-1:0] md_rd,
  input  logic [D_WIDTH-1:0]       md_data,
  output logic                     wr_en,
  output logic [ADDRESS_WIDTH-1:0] a3,
  output logic [D_WIDTH-1:0]       din,
  input  logic [ADDRESS_WIDTH-1:0] q_rs1,
  input  logic [ADDRESS_WIDTH-1:0] q_rs2,
  output logic                     q_hit1,
  output logic                     q_hit2,
  output logic                     alu_hold,
  output logic [$clog2(DEPTH+1)-1:0] pending
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam int SW = $clog2(STARVE_LIMIT+1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [SW-1:0] LIMIT    = SW'(STARVE_LIMIT);

  logic [ADDRESS_WIDTH-1:0] rd_q   [DEPTH];
  logic [D_WIDTH-1:0]       data_q [DEPTH];
  logic [DEPTH-1:0]         vld_q;
  logic [PW-1:0]            wptr, rptr;
  logic [CW-1:0]            count;
  logic [SW-1:0]            starve;

  logic alu_req, fifo_ne, md_acc, md_live;
  logic alu_win, fifo_win, byp_win, push, pop;

  // Port arbitration: ALU over FIFO head over bypass; rd==0 requests never claim the port.
  always_comb begin
    alu_req  = alu_valid && (alu_rd != '0);
    fifo_ne  = (count != '0);
    md_acc   = md_valid && md_ready;
    md_live  = md_acc && (md_rd != '0);
    alu_win  = alu_req;
    fifo_win = !alu_req && fifo_ne;
    byp_win  = !alu_req && !fifo_ne && md_live;
    push     = md_live && !byp_win;
    pop      = fifo_win;
  end

  assign md_ready = (count != FULL_CNT);
  assign pending  = count;

  // FIFO pointers, occupancy and per-slot valid bits; wptr==rptr with push&pop cannot occur (empty or full).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      vld_q <= '0;
    end else begin
      if (push) begin
        vld_q[wptr] <= 1'b1;
        wptr        <= wptr + PW'(1);
      end
      if (pop) begin
        vld_q[rptr] <= 1'b0;
        rptr        <= rptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // FIFO payload storage; only slots flagged in vld_q are meaningful.
  always_ff @(posedge clk) begin
    if (push) begin
      rd_q[wptr]   <= md_rd;
      data_q[wptr] <= md_data;
    end
  end

  // Registered write port; a3/din keep their last value when nothing wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_en <= 1'b0;
      a3    <= '0;
      din   <= '0;
    end else if (alu_win) begin
      wr_en <= 1'b1;
      a3    <= alu_rd;
      din   <= alu_data;
    end else if (fifo_win) begin
      wr_en <= 1'b1;
      a3    <= rd_q[rptr];
      din   <= data_q[rptr];
    end else if (byp_win) begin
      wr_en <= 1'b1;
      a3    <= md_rd;
      din   <= md_data;
    end else begin
      wr_en <= 1'b0;
    end
  end

  // Starvation counter: counts ALU wins over a waiting FIFO and fires a one-cycle hold at the limit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve   <= '0;
      alu_hold <= 1'b0;
    end else if (alu_win && fifo_ne) begin
      if (starve + SW'(1) == LIMIT) begin
        starve   <= '0;
        alu_hold <= 1'b1;
      end else begin
        starve   <= starve + SW'(1);
        alu_hold <= 1'b0;
      end
    end else begin
      starve   <= '0;
      alu_hold <= 1'b0;
    end
  end

  // Scoreboard: only entries still buffered count; in-flight bypass/output writes commit before the read.
  always_comb begin
    q_hit1 = 1'b0;
    q_hit2 = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (vld_q[i] && (rd_q[i] == q_rs1)) q_hit1 = 1'b1;
      if (vld_q[i] && (rd_q[i] == q_rs2)) q_hit2 = 1'b1;
    end
    if (q_rs1 == '0) q_hit1 = 1'b0;
    if (q_rs2 == '0) q_hit2 = 1'b0;
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: vector table for single-cycle arbitration plus
// hand sequences for fill/starvation/hold and mid-operation reset.
module tb_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        alu_valid = 1'b0;
  logic [4:0]  alu_rd = '0;
  logic [31:0] alu_data = '0;
  logic        md_valid = 1'b0;
  logic        md_ready;
  logic [4:0]  md_rd = '0;
  logic [31:0] md_data = '0;
  logic        wr_en;
  logic [4:0]  a3;
  logic [31:0] din;
  logic [4:0]  q_rs1 = '0;
  logic [4:0]  q_rs2 = '0;
  logic        q_hit1, q_hit2;
  logic        alu_hold;
  logic [2:0]  pending;

  int tests = 0;
  int failed = 0;

  always #5 clk = ~clk;

  wb_arbiter #(.D_WIDTH(32), .ADDRESS_WIDTH(5), .DEPTH(4), .STARVE_LIMIT(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
    .md_valid(md_valid), .md_ready(md_ready), .md_rd(md_rd), .md_data(md_data),
    .wr_en(wr_en), .a3(a3), .din(din),
    .q_rs1(q_rs1), .q_rs2(q_rs2), .q_hit1(q_hit1), .q_hit2(q_hit2),
    .alu_hold(alu_hold), .pending(pending)
  );

  typedef struct {
    logic        av;
    logic [4:0]  ard;
    logic [31:0] ad;
    logic        mv;
    logic [4:0]  mrd;
    logic [31:0] md;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        e_wr;
    logic [4:0]  e_a3;
    logic [31:0] e_din;
    logic [2:0]  e_pend;
    logic        e_rdy;
    logic        e_h1;
    logic        e_h2;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                       input logic mv, input logic [4:0] mrd, input logic [31:0] md);
    alu_valid = av; alu_rd = ard; alu_data = ad;
    md_valid = mv;  md_rd = mrd;  md_data = md;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int  edges;
    bit  hold_seen;

    // Expected state after the edge on which each row's inputs are presented.
    //          av ard  ad            mv mrd  md     rs1 rs2  wr a3  din           pend rdy h1 h2
    vecs[0] = '{1, 5,  32'hDEADBEEF, 0, 0,  32'h0,  5,  0,   1, 5,  32'hDEADBEEF, 0,   1,  0, 0};
    vecs[1] = '{0, 0,  32'h0,        1, 7,  32'h11, 7,  0,   1, 7,  32'h11,       0,   1,  0, 0};
    vecs[2] = '{0, 0,  32'h0,        1, 0,  32'h22, 0,  0,   0, 7,  32'h11,       0,   1,  0, 0};
    vecs[3] = '{1, 0,  32'h33,       0, 0,  32'h0,  0,  0,   0, 7,  32'h11,       0,   1,  0, 0};
    vecs[4] = '{1, 3,  32'hA3,       1, 9,  32'h99, 9,  3,   1, 3,  32'hA3,       1,   1,  1, 0};
    vecs[5] = '{0, 0,  32'h0,        0, 0,  32'h0,  9,  0,   1, 9,  32'h99,       0,   1,  0, 0};
    vecs[6] = '{1, 4,  32'h44,       1, 10, 32'hAA, 10, 4,   1, 4,  32'h44,       1,   1,  1, 0};
    vecs[7] = '{1, 0,  32'h55,       1, 11, 32'hBB, 11, 10,  1, 10, 32'hAA,       1,   1,  1, 0};
    vecs[8] = '{0, 0,  32'h0,        1, 12, 32'hCC, 12, 0,   1, 11, 32'hBB,       1,   1,  1, 0};
    vecs[9] = '{0, 0,  32'h0,        0, 0,  32'h0,  12, 11,  1, 12, 32'hCC,       0,   1,  0, 0};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_wr_en", 32'(wr_en), 32'd0);
    chk("rst_a3", 32'(a3), 32'd0);
    chk("rst_din", din, 32'd0);
    chk("rst_pending", 32'(pending), 32'd0);
    chk("rst_hold", 32'(alu_hold), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_md_ready", 32'(md_ready), 32'd1);

    // Table-driven single-cycle arbitration
    for (int i = 0; i < 10; i++) begin
      drive(vecs[i].av, vecs[i].ard, vecs[i].ad, vecs[i].mv, vecs[i].mrd, vecs[i].md);
      q_rs1 = vecs[i].rs1;
      q_rs2 = vecs[i].rs2;
      step();
      chk($sformatf("v%0d_wr_en", i), 32'(wr_en), 32'(vecs[i].e_wr));
      chk($sformatf("v%0d_a3", i), 32'(a3), 32'(vecs[i].e_a3));
      chk($sformatf("v%0d_din", i), din, vecs[i].e_din);
      chk($sformatf("v%0d_pending", i), 32'(pending), 32'(vecs[i].e_pend));
      chk($sformatf("v%0d_md_ready", i), 32'(md_ready), 32'(vecs[i].e_rdy));
      chk($sformatf("v%0d_hit1", i), 32'(q_hit1), 32'(vecs[i].e_h1));
      chk($sformatf("v%0d_hit2", i), 32'(q_hit2), 32'(vecs[i].e_h2));
      chk($sformatf("v%0d_hold", i), 32'(alu_hold), 32'd0);
    end

    // Fill: ALU every cycle, four md results land in the FIFO
    for (int k = 0; k < 4; k++) begin
      drive(1, 1, 32'h100 + k, 1, 5'(20 + k), 32'h200 + k);
      step();
      chk($sformatf("fill%0d_a3", k), 32'(a3), 32'd1);
      chk($sformatf("fill%0d_pending", k), 32'(pending), 32'(k + 1));
    end
    chk("full_md_ready", 32'(md_ready), 32'd0);
    q_rs1 = 5'd23;
    q_rs2 = 5'd0;
    #1;
    chk("full_hit_tail", 32'(q_hit1), 32'd1);
    chk("full_hit_r0", 32'(q_hit2), 32'd0);

    // Keep ALU winning with md still offered; 5 more wins reach the limit of 8
    edges = 0;
    hold_seen = 0;
    for (int n = 0; n < 20 && !hold_seen; n++) begin
      drive(1, 2, 32'h300 + n, 1, 5'd24, 32'h240);
      step();
      edges++;
      chk($sformatf("starve%0d_pending", n), 32'(pending), 32'd4);
      chk($sformatf("starve%0d_md_ready", n), 32'(md_ready), 32'd0);
      if (alu_hold) hold_seen = 1;
    end
    chk("hold_seen", 32'(hold_seen), 32'd1);
    chk("hold_after_edges", 32'(edges), 32'd5);

    // Hold cycle: ALU withheld, FIFO head written, md_ready still low until the next cycle
    drive(0, 0, 32'h0, 1, 5'd24, 32'h240);
    chk("hold_md_ready_same", 32'(md_ready), 32'd0);
    step();
    chk("hold_wr_en", 32'(wr_en), 32'd1);
    chk("hold_a3", 32'(a3), 32'd20);
    chk("hold_din", din, 32'h200);
    chk("hold_pending", 32'(pending), 32'd3);
    chk("hold_md_ready_next", 32'(md_ready), 32'd1);
    chk("hold_one_cycle", 32'(alu_hold), 32'd0);

    // Mid-cycle reset with three entries buffered
    drive(0, 0, 32'h0, 0, 0, 32'h0);
    q_rs1 = 5'd21;
    #2;
    rst_n = 1'b0;
    #1;
    chk("mrst_wr_en", 32'(wr_en), 32'd0);
    chk("mrst_a3", 32'(a3), 32'd0);
    chk("mrst_din", din, 32'd0);
    chk("mrst_pending", 32'(pending), 32'd0);
    chk("mrst_hit1", 32'(q_hit1), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("mrst_md_ready", 32'(md_ready), 32'd1);
    for (int n = 0; n < 4; n++) begin
      step();
      chk($sformatf("post%0d_wr_en", n), 32'(wr_en), 32'd0);
      chk($sformatf("post%0d_pending", n), 32'(pending), 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
- Writeback-port arbiter directly upstream of the register file; sole driver of its wr_en/a3/din write port.
- Merges single-cycle ALU results with results from the long-latency mul/div unit.
- Mul/div results are buffered in a small FIFO while the ALU holds the port.
- Exports a per-register pending scoreboard to the hazard unit and a starvation hold request.

Parameters:
- D_WIDTH, 32, data width.
- ADDRESS_WIDTH, 5, register index width.
- DEPTH, 4, mul/div FIFO entries; power of two, ≥2.
- STARVE_LIMIT, 8, consecutive ALU-won cycles with FIFO non-empty before alu_hold asserts; ≥1.

Ports:
- clk  in  1  clock, rising-edge.
- rst_n  in  1  asynchronous, active-low reset.
- alu_valid  in  1  ALU result valid; no ready, always accepted.
- alu_rd  in  ADDRESS_WIDTH  ALU destination register.
- alu_data  in  D_WIDTH  ALU result.
- md_valid  in  1  mul/div result valid.
- md_ready  out  1  arbiter can accept a mul/div result.
- md_rd  in  ADDRESS_WIDTH  mul/div destination register.
- md_data  in  D_WIDTH  mul/div result.
- wr_en  out  1  register-file write enable; registered.
- a3  out  ADDRESS_WIDTH  register-file write address; registered.
- din  out  D_WIDTH  register-file write data; registered.
- q_rs1, q_rs2  in  ADDRESS_WIDTH  hazard-unit source register queries.
- q_hit1, q_hit2  out  1  queried register has a buffered mul/div write pending; combinational.
- alu_hold  out  1  request to the hazard unit to withhold the ALU for one cycle; registered.
- pending  out  $clog2(DEPTH+1)  FIFO occupancy.

Behaviour:
- Reset (async assert, sync release): wr_en=0, a3=0, din=0, alu_hold=0, FIFO empty, pending=0, starve counter=0. md_ready=1 once reset releases.
- md_ready = !full. Registered occupancy only; no combinational path from any input.
- md accept: md_valid && md_ready. An accepted md with md_rd==0 is consumed and discarded; it is never stored and never written.
- ALU with alu_rd==0: treated as no request. It does not claim the write port.
- Per-cycle port winner, evaluated at rising edge; strict priority:
  1. ALU request (alu_valid, alu_rd≠0).
  2. FIFO head, if non-empty.
  3. Bypass: accepted md, rd≠0, FIFO empty → written directly without entering the FIFO.
  4. None → wr_en=0 next cycle; a3/din hold their previous values.
- Winner appears on wr_en/a3/din the cycle after the edge. Latency is 1 for ALU and bypass.
- An accepted md that does not win the port is pushed at the FIFO tail.
- Push and pop in the same cycle are legal. Occupancy is unchanged; order is preserved (FIFO strictly in order).
- Full: push is impossible because md_ready=0. A pop in that cycle raises md_ready on the next cycle, not the same cycle.
- Scoreboard: q_hitN = 1 iff q_rsN≠0 and any valid FIFO entry has rd==q_rsN.
  - Bypass data and the output register are not counted: the register file commits at the negedge of the output cycle, before the next read edge.
- Starvation:
  - Counter increments on each edge where the ALU wins while the FIFO is non-empty.
  - Counter clears when the FIFO wins or the FIFO is empty.
  - On reaching STARVE_LIMIT: alu_hold=1 for exactly one cycle, then the counter clears.
  - The hazard unit must keep alu_valid=0 during that hold cycle, so the FIFO head wins.
  - If alu_valid is nonetheless asserted during hold, the ALU still wins (no data loss). The counter restarts from 0.
- No write is ever dropped except rd==0 cases. Every accepted md with rd≠0 is written exactly once.
- Reset mid-operation: all buffered entries are lost and outputs return to reset values immediately. Upstream must reissue.

Test Plan:
- Reset → wr_en=0, pending=0, md_ready=1. ALU rd=5 data=0xDEADBEEF → next cycle wr_en=1, a3=5, din=0xDEADBEEF.
- FIFO empty, no ALU, md rd=7 data=0x11 → next cycle a3=7, din=0x11; pending stays 0. md rd=0 → wr_en=0, no write.
- ALU and md (rd=9) in the same cycle → ALU written first; pending=1 and q_rs1=9 gives q_hit1=1. Following idle cycle writes rd=9; then pending=0 and q_hit1=0.
- ALU valid every cycle, md offers 4 results → md_ready drops to 0 after the 4th accept, pending=4.
- Continuing the case above: alu_hold pulses after 8 ALU wins. During the hold cycle (alu_valid=0) the head entry is written, pending=3, and md_ready returns to 1 the following cycle.
- pending=3, assert rst_n=0 mid-cycle → outputs clear immediately. After release, no stale writes appear and pending=0.
